// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer: FSM state encoding,
// activation selectors and the accumulator width rule.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    localparam ACT_RELU = "RELU";
    localparam ACT_NONE = "NONE";

    // Wide enough for K*K full-scale signed products, so the sum can never wrap.
    function automatic int acc_width(input int dw, input int kw, input int k);
        return dw + kw + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: clr loads the first product of a window, en adds
// each following product. clr has priority so a 1x1 kernel still works.
module conv_mac #(
    parameter int AW    = 8,
    parameter int BW    = 8,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [AW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] w_a_ext;
    logic signed [ACC_W-1:0] w_b_ext;
    logic signed [ACC_W-1:0] w_prod;

    assign w_a_ext = {{(ACC_W - AW){a[AW-1]}}, a};
    assign w_b_ext = {{(ACC_W - BW){b[BW-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= w_prod;
        end else if (en) begin
            acc <= acc + w_prod;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one convolution pass: fetches K*K pixel/tap pairs per output window,
// accumulates them in conv_mac, applies the activation and streams results over valid/ready.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int  DATA_WIDTH  = 8,
    parameter int  KDATA_WIDTH = 8,
    parameter int  KERNEL_SIZE = 3,
    parameter int  IMGROW      = 7,
    parameter int  IMGCOL      = 7,
    parameter      ACTIVATION  = ACT_RELU,
    localparam int ACC_WIDTH   = acc_width(DATA_WIDTH, KDATA_WIDTH, KERNEL_SIZE),
    localparam int RW          = (IMGROW > 1) ? $clog2(IMGROW) : 1,
    localparam int CW          = (IMGCOL > 1) ? $clog2(IMGCOL) : 1,
    localparam int KW          = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        img_rd_en,
    output logic [RW-1:0]               img_row,
    output logic [CW-1:0]               img_col,
    input  logic signed [DATA_WIDTH-1:0]  img_rd_data,
    output logic [KW-1:0]               k_row,
    output logic [KW-1:0]               k_col,
    input  logic signed [KDATA_WIDTH-1:0] k_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic [RW-1:0]               out_row,
    output logic [CW-1:0]               out_col
);

    localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMGROW - KERNEL_SIZE);
    localparam logic [CW-1:0] COL_LAST = CW'(IMGCOL - KERNEL_SIZE);
    localparam bit            USE_RELU = (ACTIVATION == ACT_RELU);

    if (KERNEL_SIZE > IMGROW || KERNEL_SIZE > IMGCOL) begin : g_bad_geometry
        $error("conv_sequencer: KERNEL_SIZE must not exceed IMGROW or IMGCOL");
    end
    if (ACTIVATION != ACT_RELU && ACTIVATION != ACT_NONE) begin : g_bad_activation
        $error("conv_sequencer: ACTIVATION must be RELU or NONE");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [KW-1:0]           r_kr;
    logic [KW-1:0]           r_kc;
    logic [RW-1:0]           r_orow;
    logic [CW-1:0]           r_ocol;
    logic                    r_rd_vld;
    logic                    r_tap0;
    logic                    w_last_tap;
    logic                    w_last_out;
    logic                    w_mac_clr;
    logic                    w_mac_en;
    logic signed [ACC_WIDTH-1:0] w_acc;

    assign w_last_tap = (r_kr == K_LAST) && (r_kc == K_LAST);
    assign w_last_out = (r_orow == ROW_LAST) && (r_ocol == COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        img_rd_en   = (r_state == FETCH);
        out_valid   = (r_state == EMIT);
        case (r_state)
            IDLE:    if (start) w_state_nxt = FETCH;
            FETCH:   if (w_last_tap) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = EMIT;
            EMIT:    if (out_ready) w_state_nxt = w_last_out ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    // r_rd_vld/r_tap0 follow the 1-cycle buffer latency; abort drops the word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kr     <= '0;
            r_kc     <= '0;
            r_orow   <= '0;
            r_ocol   <= '0;
            r_rd_vld <= 1'b0;
            r_tap0   <= 1'b0;
        end else if (abort) begin
            r_rd_vld <= 1'b0;
            r_tap0   <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == FETCH);
            r_tap0   <= (r_state == FETCH) && (r_kr == '0) && (r_kc == '0);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_kr   <= '0;
                        r_kc   <= '0;
                        r_orow <= '0;
                        r_ocol <= '0;
                    end
                end
                FETCH: begin
                    if (r_kc == K_LAST) begin
                        r_kc <= '0;
                        r_kr <= w_last_tap ? '0 : r_kr + KW'(1);
                    end else begin
                        r_kc <= r_kc + KW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready && !w_last_out) begin
                        if (r_ocol == COL_LAST) begin
                            r_ocol <= '0;
                            r_orow <= r_orow + RW'(1);
                        end else begin
                            r_ocol <= r_ocol + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_mac_clr = r_tap0 & ~abort;
    assign w_mac_en  = r_rd_vld & ~abort;

    conv_mac #(
        .AW    (DATA_WIDTH),
        .BW    (KDATA_WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_mac_clr),
        .en  (w_mac_en),
        .a   (img_rd_data),
        .b   (k_rd_data),
        .acc (w_acc)
    );

    assign img_row = r_orow + RW'(r_kr);
    assign img_col = r_ocol + CW'(r_kc);
    assign k_row   = r_kr;
    assign k_col   = r_kc;
    assign out_row = r_orow;
    assign out_col = r_ocol;

    // The accumulator is frozen from DRAIN->EMIT until the next window's first tap lands,
    // so the activated sum is stable for the whole EMIT handshake without a copy register.
    assign out_data = (USE_RELU && w_acc[ACC_WIDTH-1]) ? '0 : w_acc;

endmodule
